stream_packet_dispatcher: RTL and testbench

Parametrised successor of the streaming packet parser. Buffers length-prefixed packets from the host stream in an internal show-ahead FIFO. Forwards each complete packet to one idle core, chosen round-robin, using a valid/ready handshake. Kicks the loader with a base address derived from the packet id, and discards malformed or oversize packets without stalling the stream.

---
 rtl/stream_packet_dispatcher.sv | 272 +++++++++++++++++++++++++++
 tb/tb_stream_packet_dispatcher.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packet_dispatcher.sv
// Buffers length-prefixed packets in a show-ahead FIFO and forwards each complete packet to
// an idle core picked round-robin; malformed or oversize packets are drained and counted.
module stream_packet_dispatcher #(
    parameter int DATA_W     = 512,
    parameter int CORES      = 4,
    parameter int FIFO_DEPTH = 64,
    parameter int LEN_W      = 32,
    parameter int ID_W       = 32,
    parameter int ADDR_SHIFT = 15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        snk_data,
    input  logic                     snk_valid,
    output logic                     snk_ready,
    input  logic [CORES-1:0]         core_idle,
    output logic [$clog2(CORES)-1:0] target_core,
    output logic                     target_core_valid,
    output logic                     target_snk_sop,
    output logic                     target_snk_eop,
    output logic                     target_snk_valid,
    input  logic                     target_snk_ready,
    output logic [DATA_W-1:0]        target_snk_data,
    output logic                     loader_kick,
    output logic [63:0]              loader_memory_base_addr,
    output logic                     length_error,
    output logic [15:0]              drop_count
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int CW    = $clog2(CORES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_KICK,
        S_DROP
    } state_t;

    state_t state_q, state_d;

    // Receive FIFO
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              snk_ready_q, snk_ready_d;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [DATA_W-1:0] head;

    // Header fields of the word at the FIFO head
    logic [LEN_W-1:0]  hdr_len;
    logic [ID_W-1:0]   hdr_id;
    logic              hdr_zero;
    logic              hdr_big;
    logic              hdr_complete;

    // Round-robin arbitration
    logic [CW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     grant_idx;
    logic              grant_found;

    // Output beat register and packet bookkeeping
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_sop_q, out_sop_d;
    logic              out_eop_q, out_eop_d;
    logic [CW-1:0]     core_q, core_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [63:0]       addr_q, addr_d;
    logic              length_error_q, length_error_d;
    logic [15:0]       drop_count_q, drop_count_d;

    // FSM decision terms
    logic              start_send;
    logic              start_drop;
    logic              xfer;
    logic              send_done;
    logic              drop_pop;
    logic              drop_done;

    assign head         = mem[rd_ptr_q];
    assign hdr_len      = head[LEN_W-1:0];
    assign hdr_id       = head[LEN_W+ID_W-1:LEN_W];
    assign fifo_empty   = (count_q == '0);
    assign push         = snk_valid & snk_ready_q;
    assign hdr_zero     = (hdr_len == '0);
    assign hdr_big      = (hdr_len > LEN_W'(FIFO_DEPTH));
    assign hdr_complete = (LEN_W'(count_q) >= hdr_len);

    assign start_drop = (state_q == S_IDLE) && !fifo_empty && (hdr_zero || hdr_big);
    assign start_send = (state_q == S_IDLE) && !fifo_empty && !hdr_zero && !hdr_big
                        && hdr_complete && grant_found;
    assign xfer       = out_valid_q & target_snk_ready;
    assign send_done  = (state_q == S_SEND) && xfer && out_eop_q;
    assign drop_pop   = (state_q == S_DROP) && !fifo_empty;
    assign drop_done  = drop_pop && (rem_q == LEN_W'(1));

    // First set core_idle bit strictly after the pointer, wrapping around.
    always_comb begin
        logic [CW-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        for (int i = 1; i <= CORES; i++) begin
            cand = CW'((int'(ptr_q) + i) % CORES);
            if (!grant_found && core_idle[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_drop) begin
                    state_d = S_DROP;
                end else if (start_send) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: if (send_done) state_d = S_KICK;
            S_KICK: state_d = S_IDLE;
            S_DROP: if (drop_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        loader_kick             = (state_q == S_KICK);
        loader_memory_base_addr = addr_q;
        snk_ready               = snk_ready_q;
        target_snk_valid        = out_valid_q;
        target_snk_data         = out_data_q;
        target_snk_sop          = out_sop_q;
        target_snk_eop          = out_eop_q;
        target_core_valid       = out_valid_q & out_sop_q;
        target_core             = core_q;
        length_error            = length_error_q;
        drop_count              = drop_count_q;
    end

    // Datapath: beat loading, FIFO pops, drop accounting.
    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        pop            = 1'b0;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_sop_d      = out_sop_q;
        out_eop_d      = out_eop_q;
        core_d         = core_q;
        ptr_d          = ptr_q;
        rem_d          = rem_q;
        id_d           = id_q;
        addr_d         = addr_q;
        length_error_d = 1'b0;
        drop_count_d   = drop_count_q;

        if (start_send) begin
            pop         = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = head;
            out_sop_d   = 1'b1;
            out_eop_d   = (hdr_len == LEN_W'(1));
            rem_d       = hdr_len - LEN_W'(1);
            id_d        = hdr_id;
            ptr_d       = grant_idx;
            core_d      = grant_idx;
        end else if (start_drop) begin
            // A zero-length header still occupies one word that must be discarded.
            rem_d = hdr_zero ? LEN_W'(1) : hdr_len;
        end

        if ((state_q == S_SEND) && xfer) begin
            if (out_eop_q) begin
                out_valid_d = 1'b0;
                out_sop_d   = 1'b0;
                out_eop_d   = 1'b0;
                addr_d      = 64'(id_q) << ADDR_SHIFT;
            end else begin
                pop        = 1'b1;
                out_data_d = head;
                out_sop_d  = 1'b0;
                out_eop_d  = (rem_q == LEN_W'(1));
                rem_d      = rem_q - LEN_W'(1);
            end
        end

        if (drop_pop) begin
            pop   = 1'b1;
            rem_d = rem_q - LEN_W'(1);
        end

        if (drop_done) begin
            length_error_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
    end

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        snk_ready_d = (count_d < CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            snk_ready_q    <= 1'b0;
            ptr_q          <= CW'(CORES - 1);
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_sop_q      <= 1'b0;
            out_eop_q      <= 1'b0;
            core_q         <= '0;
            rem_q          <= '0;
            id_q           <= '0;
            addr_q         <= '0;
            length_error_q <= 1'b0;
            drop_count_q   <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            snk_ready_q    <= snk_ready_d;
            ptr_q          <= ptr_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_sop_q      <= out_sop_d;
            out_eop_q      <= out_eop_d;
            core_q         <= core_d;
            rem_q          <= rem_d;
            id_q           <= id_d;
            addr_q         <= addr_d;
            length_error_q <= length_error_d;
            drop_count_q   <= drop_count_d;
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by the reset
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= snk_data;
        end
    end

endmodule

// File: tb/tb_stream_packet_dispatcher.sv
// Self-checking bench for stream_packet_dispatcher: directed scenarios with random payloads,
// compared against a packet-level reference model of dispatch, kicks and drops.
module tb_stream_packet_dispatcher;

    localparam int DATA_W     = 512;
    localparam int CORES      = 4;
    localparam int FIFO_DEPTH = 64;
    localparam int LEN_W      = 32;
    localparam int ID_W       = 32;
    localparam int ADDR_SHIFT = 15;
    localparam int CW         = $clog2(CORES);

    typedef logic [DATA_W-1:0] word_t;

    logic              clk = 1'b0;
    logic              reset_n;
    word_t             snk_data;
    logic              snk_valid;
    logic              snk_ready;
    logic [CORES-1:0]  core_idle;
    logic [CW-1:0]     target_core;
    logic              target_core_valid;
    logic              target_snk_sop;
    logic              target_snk_eop;
    logic              target_snk_valid;
    logic              target_snk_ready;
    word_t             target_snk_data;
    logic              loader_kick;
    logic [63:0]       loader_memory_base_addr;
    logic              length_error;
    logic [15:0]       drop_count;

    always #5 clk = ~clk;

    stream_packet_dispatcher #(
        .DATA_W(DATA_W), .CORES(CORES), .FIFO_DEPTH(FIFO_DEPTH),
        .LEN_W(LEN_W), .ID_W(ID_W), .ADDR_SHIFT(ADDR_SHIFT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .snk_data(snk_data),
        .snk_valid(snk_valid),
        .snk_ready(snk_ready),
        .core_idle(core_idle),
        .target_core(target_core),
        .target_core_valid(target_core_valid),
        .target_snk_sop(target_snk_sop),
        .target_snk_eop(target_snk_eop),
        .target_snk_valid(target_snk_valid),
        .target_snk_ready(target_snk_ready),
        .target_snk_data(target_snk_data),
        .loader_kick(loader_kick),
        .loader_memory_base_addr(loader_memory_base_addr),
        .length_error(length_error),
        .drop_count(drop_count)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Observed traffic
    word_t       obs_data[$];
    logic        obs_sop[$];
    logic        obs_eop[$];
    logic        obs_tcv[$];
    logic [CW-1:0] obs_core[$];
    int          obs_cyc[$];
    logic [63:0] obs_addr[$];
    int          obs_err   = 0;
    int          hold_viol = 0;

    // Reference model expectations
    word_t       exp_data[$];
    logic        exp_sop[$];
    logic        exp_eop[$];
    logic [CW-1:0] exp_core[$];
    logic [63:0] exp_addr[$];
    int          exp_drops = 0;
    int          rr_last   = CORES - 1;

    word_t       pkt[$];

    always @(posedge clk) cyc++;

    logic  held = 1'b0;
    word_t held_data;
    logic  held_sop, held_eop;

    always @(negedge clk) begin
        if (!reset_n) begin
            held = 1'b0;
        end else begin
            if (held && (!target_snk_valid || target_snk_data !== held_data ||
                         target_snk_sop !== held_sop || target_snk_eop !== held_eop))
                hold_viol++;
            held      = target_snk_valid && !target_snk_ready;
            held_data = target_snk_data;
            held_sop  = target_snk_sop;
            held_eop  = target_snk_eop;
            if (target_snk_valid && target_snk_ready) begin
                obs_data.push_back(target_snk_data);
                obs_sop.push_back(target_snk_sop);
                obs_eop.push_back(target_snk_eop);
                obs_tcv.push_back(target_core_valid);
                obs_core.push_back(target_core);
                obs_cyc.push_back(cyc);
            end
            if (loader_kick) obs_addr.push_back(loader_memory_base_addr);
            if (length_error) obs_err++;
        end
    end

    task automatic check(input string tag, input word_t obs, input word_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Builds pkt: header with the given length/id followed by nwords-1 random payload words.
    task automatic make_packet(input int len, input int id, input int nwords);
        word_t h;
        pkt.delete();
        h = rand_word();
        h[LEN_W-1:0]           = LEN_W'(len);
        h[LEN_W+ID_W-1:LEN_W]  = ID_W'(id);
        pkt.push_back(h);
        for (int i = 1; i < nwords; i++) pkt.push_back(rand_word());
    endtask

    // Packet-level model: drop bad lengths, otherwise round-robin to the next idle core.
    task automatic model_packet(input logic [CORES-1:0] mask);
        longint len;
        len = longint'(pkt[0][LEN_W-1:0]);
        if (len == 0 || len > FIFO_DEPTH) begin
            exp_drops++;
            return;
        end
        for (int i = 1; i <= CORES; i++) begin
            if (mask[(rr_last + i) % CORES]) begin
                rr_last = (rr_last + i) % CORES;
                break;
            end
        end
        for (int k = 0; k < len; k++) begin
            exp_data.push_back(pkt[k]);
            exp_sop.push_back(k == 0);
            exp_eop.push_back(k == len - 1);
            exp_core.push_back(CW'(rr_last));
        end
        exp_addr.push_back(64'(pkt[0][LEN_W+ID_W-1:LEN_W]) << ADDR_SHIFT);
    endtask

    task automatic push_word(input word_t w);
        logic accepted;
        int   guard;
        guard     = 0;
        accepted  = 1'b0;
        snk_data  = w;
        snk_valid = 1'b1;
        while (!accepted && guard < 2000) begin
            @(negedge clk);
            accepted = snk_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        snk_valid = 1'b0;
        if (!accepted) check("push_timeout", 0, 1'b1);
    endtask

    task automatic push_range(input int from, input int to);
        for (int i = from; i < to; i++) push_word(pkt[i]);
    endtask

    task automatic wait_events(input int kicks, input int errs, input int budget);
        int n;
        n = 0;
        while ((obs_addr.size() < kicks || obs_err < errs) && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".beats"}, obs_data.size(), exp_data.size());
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            check({tag, ".data"}, obs_data[i], exp_data[i]);
            check({tag, ".sop"},  obs_sop[i],  exp_sop[i]);
            check({tag, ".eop"},  obs_eop[i],  exp_eop[i]);
            check({tag, ".tcv"},  obs_tcv[i],  exp_sop[i]);
            check({tag, ".core"}, obs_core[i], exp_core[i]);
        end
        check({tag, ".kicks"}, obs_addr.size(), exp_addr.size());
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
            check({tag, ".addr"}, obs_addr[i], exp_addr[i]);
        check({tag, ".drops"}, obs_err, exp_drops);
        check({tag, ".hold"}, hold_viol, 0);
        obs_data.delete(); obs_sop.delete(); obs_eop.delete(); obs_tcv.delete();
        obs_core.delete(); obs_cyc.delete(); obs_addr.delete();
        exp_data.delete(); exp_sop.delete(); exp_eop.delete(); exp_core.delete();
        exp_addr.delete();
        obs_err   = 0;
        exp_drops = 0;
        hold_viol = 0;
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, ".snk_ready"}, snk_ready, 1'b0);
        check({tag, ".valid"},     target_snk_valid, 1'b0);
        check({tag, ".sop"},       target_snk_sop, 1'b0);
        check({tag, ".tcv"},       target_core_valid, 1'b0);
        check({tag, ".kick"},      loader_kick, 1'b0);
        check({tag, ".addr"},      loader_memory_base_addr, 64'd0);
        check({tag, ".lerr"},      length_error, 1'b0);
        check({tag, ".drops"},     drop_count, 16'd0);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        snk_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet_outputs("reset");
        obs_data.delete(); obs_sop.delete(); obs_eop.delete(); obs_tcv.delete();
        obs_core.delete(); obs_cyc.delete(); obs_addr.delete();
        exp_data.delete(); exp_sop.delete(); exp_eop.delete(); exp_core.delete();
        exp_addr.delete();
        obs_err   = 0;
        exp_drops = 0;
        hold_viol = 0;
        rr_last   = CORES - 1;
        reset_n   = 1'b1;
        #1;
        check("release.snk_ready_low", snk_ready, 1'b0);
        @(posedge clk);
        #1;
        check("release.snk_ready_high", snk_ready, 1'b1);
    endtask

    initial begin
        logic pattern [7];
        reset_n          = 1'b0;
        snk_data         = '0;
        snk_valid        = 1'b0;
        core_idle        = '0;
        target_snk_ready = 1'b1;
        pattern          = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // 1: single 3-word packet to core 0, consecutive beats, then kick.
        do_reset();
        core_idle = 4'b0001;
        make_packet(3, 2, 3);
        model_packet(core_idle);
        push_range(0, 3);
        wait_events(1, 0, 200);
        if (obs_cyc.size() == 3) begin
            check("t1.consec01", obs_cyc[1] - obs_cyc[0], 1);
            check("t1.consec12", obs_cyc[2] - obs_cyc[1], 1);
        end else begin
            check("t1.beat_count", obs_cyc.size(), 3);
        end
        check("t1.base_addr", loader_memory_base_addr, 64'h10000);
        compare_all("t1");

        // 2: five back-to-back 1-word packets, round-robin over all cores.
        do_reset();
        core_idle = 4'b1111;
        for (int p = 0; p < 5; p++) begin
            make_packet(1, int'($urandom_range(0, 1000)), 1);
            model_packet(core_idle);
            push_range(0, 1);
        end
        wait_events(5, 0, 300);
        compare_all("t2");

        // 3: 4-word packet under a toggling ready pattern.
        core_idle = '0;
        make_packet(4, int'($urandom_range(0, 65535)), 4);
        model_packet(4'b0001);
        push_range(0, 4);
        core_idle = 4'b0001;
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            target_snk_ready = pattern[i];
            @(posedge clk);
            #1;
        end
        target_snk_ready = 1'b1;
        wait_events(1, 0, 200);
        compare_all("t3");

        // 4: oversize header drained without output, next packet still dispatched.
        core_idle = 4'b1111;
        make_packet(100, 7, 100);
        model_packet(core_idle);
        push_range(0, 100);
        make_packet(2, int'($urandom_range(0, 65535)), 2);
        model_packet(core_idle);
        push_range(0, 2);
        wait_events(1, 1, 500);
        check("t4.drop_count", drop_count, 16'd1);
        compare_all("t4");

        // 5: incomplete packet and no idle core both hold dispatch off.
        make_packet(5, int'($urandom_range(0, 65535)), 5);
        push_range(0, 4);
        repeat (10) @(posedge clk);
        #1;
        check("t5.no_out_partial", obs_data.size(), 0);
        core_idle = '0;
        push_range(4, 5);
        repeat (10) @(posedge clk);
        #1;
        check("t5.no_out_no_core", obs_data.size(), 0);
        model_packet(4'b0100);
        core_idle = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        check("t5.start_valid", target_snk_valid, 1'b1);
        check("t5.start_sop", target_snk_sop, 1'b1);
        check("t5.start_core", target_core, exp_core[0]);
        wait_events(1, 0, 200);
        compare_all("t5");

        // 6: fill the FIFO, then reset in the middle of a stalled packet.
        core_idle = '0;
        make_packet(FIFO_DEPTH, 3, FIFO_DEPTH);
        push_range(0, FIFO_DEPTH);
        @(negedge clk);
        check("t6.full_ready", snk_ready, 1'b0);
        target_snk_ready = 1'b0;
        core_idle        = 4'b0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t6.in_send", target_snk_valid, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        check_quiet_outputs("t6.async");
        target_snk_ready = 1'b1;
        do_reset();
        core_idle = 4'b0001;
        make_packet(1, 9, 1);
        model_packet(core_idle);
        push_range(0, 1);
        wait_events(1, 0, 200);
        compare_all("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
